// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating multiplexer: arbitration mode
// constants and the channel-index width helper.
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Grant generator: rotates the request vector so the search origin sits at
// bit 0, picks the lowest set bit, then rotates the pick back. With RR set
// the origin is ptr+1 (wrapping), otherwise it is always channel 0.
module rr_grant
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int RR = ARB_RR,
    localparam int CW = chan_w(N)
) (
    input  logic [N-1:0]  in_valid,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx
);

    logic [CW-1:0] start;
    logic [N-1:0]  rot;
    logic [N-1:0]  pick_oh;
    logic [CW-1:0] pick;
    logic [CW:0]   sum;

    // Rotate, priority-pick, rotate back, and encode the granted channel.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        start = '0;
        if (RR == ARB_RR) begin
            start = (ptr == CW'(N - 1)) ? '0 : ptr + CW'(1);
        end

        rot     = N'({in_valid, in_valid} >> start);
        pick_oh = rot & (~rot + N'(1));

        pick = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) pick = CW'(j);
        end

        // Left-rotate by start == right-shift of the doubled vector by N-start.
        grant = N'({pick_oh, pick_oh} >> (N - int'(start)));

        sum = {1'b0, pick} + {1'b0, start};
        if (sum >= (CW + 1)'(N)) sum = sum - (CW + 1)'(N);
        idx = sum[CW-1:0];
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating multiplexer with valid/ready on every channel and a
// registered output stage. The output register reloads whenever it is empty
// or being drained, so a steady consumer sees one word per cycle.
module arb_mux
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    parameter  int RR = ARB_RR,
    localparam int CW = chan_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    input  logic           out_ready
);

    logic          load_en;
    logic [N-1:0]  grant;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] ptr;
    logic [W-1:0]  sel_data;

    assign load_en  = !out_valid || out_ready;
    assign in_ready = grant & {N{load_en}};

    rr_grant #(
        .N  (N),
        .RR (RR)
    ) u_grant (
        .in_valid (in_valid),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (grant_idx)
    );

    // AND-OR data select over the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(N - 1);
        end else if (load_en) begin
            if (|grant) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= grant_idx;
                if (RR == ARB_RR) ptr <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin instance and one fixed-priority
// instance. Expected output words go into per-instance queues when stimulus
// is issued; monitors pop and compare on every output transfer.
module tb_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [7:0] data;
        logic [1:0] chan;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;

    logic [3:0]   in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [1:0]   out_chan;
    logic         out_ready;

    logic [3:0]   fp_in_valid;
    logic [31:0]  fp_in_data;
    logic [3:0]   fp_in_ready;
    logic         fp_out_valid;
    logic [7:0]   fp_out_data;
    logic [1:0]   fp_out_chan;
    logic         fp_out_ready;

    exp_t rr_q[$];
    exp_t fp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arb_mux #(.N(N), .W(W), .RR(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    arb_mux #(.N(N), .W(W), .RR(0)) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fp_in_valid),
        .in_data   (fp_in_data),
        .in_ready  (fp_in_ready),
        .out_valid (fp_out_valid),
        .out_data  (fp_out_data),
        .out_chan  (fp_out_chan),
        .out_ready (fp_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rr(input logic [7:0] d, input logic [1:0] c);
        rr_q.push_back(exp_t'{data: d, chan: c});
    endtask

    task automatic push_fp(input logic [7:0] d, input logic [1:0] c);
        fp_q.push_back(exp_t'{data: d, chan: c});
    endtask

    // Drive point: just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Round-robin monitor: a transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (rr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rr_unexpected_word: got %0h/%0d expected none", out_data, out_chan);
            end else begin
                exp_t e;
                e = rr_q.pop_front();
                check("rr_out_data", out_data, e.data);
                check("rr_out_chan", out_chan, e.chan);
            end
        end
    end

    // Fixed-priority monitor.
    always @(negedge clk) begin
        if (!rst && fp_out_valid && fp_out_ready) begin
            if (fp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fp_unexpected_word: got %0h/%0d expected none", fp_out_data, fp_out_chan);
            end else begin
                exp_t e;
                e = fp_q.pop_front();
                check("fp_out_data", fp_out_data, e.data);
                check("fp_out_chan", fp_out_chan, e.chan);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = '0;
        in_data      = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready    = 1'b0;
        fp_in_valid  = '0;
        fp_in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        fp_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_chan",  out_chan,  0);
        check("rst_in_ready",  in_ready,  0);
        rst = 1'b0;

        // Round-robin rotation, all valid, no bubbles
        cyc();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        push_rr(8'h11, 0);
        push_rr(8'h22, 1);
        push_rr(8'h33, 2);
        push_rr(8'h44, 3);
        push_rr(8'h11, 0);
        @(negedge clk);
        check("rot_first_ready", in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 4) in_valid = '0;
            @(negedge clk);
            check("rot_no_bubble", out_valid, 1);
        end
        cyc();
        @(negedge clk);
        check("rot_drained", out_valid, 0);

        // Backpressure: 22 held while the consumer stalls
        cyc();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        push_rr(8'h22, 1);
        @(negedge clk);
        check("bp_first_ready", in_ready, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            check("bp_in_ready",  in_ready,  4'b0000);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data",  out_data,  8'h22);
            check("bp_out_chan",  out_chan,  1);
        end
        cyc();
        out_ready = 1'b1;
        push_rr(8'h33, 2);
        @(negedge clk);
        check("bp_release_ready", in_ready, 4'b0100);
        cyc();
        in_valid = '0;
        @(negedge clk);
        check("bp_next_chan", out_chan, 2);
        cyc();
        @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Sparse requests and wrap-around (ptr is 2 here)
        cyc();
        in_valid = 4'b1000;
        push_rr(8'h44, 3);
        @(negedge clk);
        check("wrap_ready_a", in_ready, 4'b1000);
        cyc();
        in_valid = 4'b1001;
        push_rr(8'h11, 0);
        @(negedge clk);
        check("wrap_ready_b", in_ready, 4'b0001);
        cyc();
        push_rr(8'h44, 3);
        @(negedge clk);
        check("wrap_ready_c", in_ready, 4'b1000);
        cyc();
        in_valid = 4'b1000;
        push_rr(8'h44, 3);
        @(negedge clk);
        check("wrap_ready_self", in_ready, 4'b1000);
        cyc();
        in_valid = '0;
        cyc();
        @(negedge clk);
        check("idle_drain", out_valid, 0);

        // Single-cycle request on channel 2 accepted with no wait
        cyc();
        in_data[23:16] = 8'hA5;
        in_valid       = 4'b0100;
        push_rr(8'hA5, 2);
        @(negedge clk);
        check("single_ready", in_ready, 4'b0100);
        cyc();
        in_valid = '0;
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_data",  out_data,  8'hA5);
        cyc();
        @(negedge clk);
        check("single_drained", out_valid, 0);

        // Reset mid-stream discards the held word
        cyc();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        cyc();
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_chan",  out_chan,  3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    out_valid, 0);
        check("mid_rst_data",     out_data,  0);
        check("mid_rst_chan",     out_chan,  0);
        check("mid_rst_in_ready", in_ready,  4'b0001);
        @(negedge clk);
        rst = 1'b0;
        push_rr(8'h11, 0);
        cyc();
        out_ready = 1'b1;
        in_valid  = '0;
        @(negedge clk);
        check("post_rst_chan", out_chan, 0);
        cyc();
        @(negedge clk);
        check("post_rst_drained", out_valid, 0);

        // Fixed priority: channel 1 starves channel 2
        cyc();
        fp_in_valid  = 4'b0110;
        fp_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_fp(8'h22, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fp_ready_ch1", fp_in_ready, 4'b0010);
            cyc();
        end
        fp_in_valid = 4'b0100;
        push_fp(8'h33, 2);
        @(negedge clk);
        check("fp_ready_ch2", fp_in_ready, 4'b0100);
        cyc();
        fp_in_valid = '0;
        cyc();
        @(negedge clk);
        check("fp_drained", fp_out_valid, 0);

        check("rr_queue_empty", rr_q.size(), 0);
        check("fp_queue_empty", fp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-to-1 arbitrating multiplexer with valid/ready handshakes and a registered output stage. It generalises the 4x1 decoder-based mux to N channels of W bits, replacing the external select with an internal round-robin or fixed-priority arbiter. It sits between several producer channels and a single shared consumer.

## Interface

**Parameters**
- N, default 4: channel count, legal range 2..16.
- W, default 8: data width per channel.
- RR, default 1: arbitration mode. 1 = round-robin; 0 = fixed priority, with channel 0 highest.

**Ports**
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, N: per-channel request.
- in_data, input, N*W: channel i occupies bits [i*W +: W].
- in_ready, output, N: per-channel accept; combinational.
- out_valid, output, 1: output register holds a word.
- out_data, output, W: registered data.
- out_chan, output, CW = $clog2(N): index of the source channel of out_data.
- out_ready, input, 1: consumer accept.

## Operation

- A transfer on input channel i happens in a cycle where in_valid[i] && in_ready[i].
- A transfer on the output happens in a cycle where out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register can accept a new word when it is empty or is being drained in the same cycle.
- grant is one-hot over the channels with in_valid set, or all-zero when no channel is valid.
  - RR=0: grant selects the lowest set index.
  - RR=1: grant selects the first set index searching ptr+1, ptr+2, … with wrap modulo N.
- in_ready[i] = load_en && grant[i]. At most one in_ready bit is high in any cycle.
- in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- When load_en is high and any channel is valid, on the clock edge:
  - out_data is loaded from the granted channel's in_data.
  - out_chan is loaded with the granted index.
  - out_valid is set to 1.
  - ptr is loaded with the granted index. This applies for RR=1 only; for RR=0, ptr is unused.
- When load_en is high and no channel is valid: out_valid goes to 0, and out_data and out_chan hold their values.
- When load_en is low: all state holds and in_ready is all zero.
- Output stability: while out_valid && !out_ready, out_data and out_chan are stable.
- Producer obligation: a producer holds in_valid and in_data stable until its transfer completes. The arbiter does not rely on this, because it re-evaluates the grant every cycle.

## Timing

- Reset values, applied asynchronously on rst:
  - out_valid = 0, out_data = 0, out_chan = 0.
  - ptr = N-1, so channel 0 wins first in RR mode.
  - in_ready follows from out_valid = 0, i.e. it equals grant.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k. It is visible in the cycle following the input transfer.
- Throughput: one word per cycle while out_ready stays high.
- Simultaneous drain and load: a new word is written in the same cycle the old one leaves; out_valid stays 1 with no bubble.
- RR fairness: with all N channels continuously valid and out_ready high, grants run in the order 0, 1, …, N-1, 0, …. Each channel waits at most N-1 transfers.
- Wrap-around: if ptr = N-1, the search starts at channel 0.
- If only the channel at ptr is valid, it is granted again after the full search.
- Reset mid-operation: any held word is discarded and ptr returns to N-1. in_ready may change asynchronously with rst.
- Width rule: CW = $clog2(N). For N not a power of two, out_chan never exceeds N-1.

## Structure

- Shared package arb_pkg holds:
  - a function chan_w(n) returning max(1, $clog2(n));
  - the mode constants ARB_FIXED = 0 and ARB_RR = 1.
- Sub-module rr_grant(N, RR): takes in_valid and ptr, and outputs the one-hot grant plus the encoded index.
  - It is implemented as a rotate, then a priority pick, then a rotate back.
  - It is the generalised successor of the 2-to-4 decoder.
- The top level holds the output register, ptr, the load_en logic, and the data select. The data select is AND-OR over the one-hot grant, matching the existing mux style.

## Test plan

1. **Reset:** assert rst mid-stream with out_valid = 1 → out_valid = 0, out_data = 0 and out_chan = 0 immediately. After release, with in_valid = 4'b1111, the first grant is channel 0.
2. **RR rotation:** N=4, W=8, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, all valid, out_ready = 1 → out_data sequence 11, 22, 33, 44, 11, with out_chan 0, 1, 2, 3, 0 and no bubbles.
3. **Backpressure:** hold out_ready = 0 with out_valid = 1 and out_data = 8'h22 for 5 cycles → in_ready = 0, and out_data/out_chan stay stable. On out_ready = 1, the next grant is channel 2.
4. **Sparse wrap:** ptr = 3, in_valid = 4'b1001 → channel 0 is granted next, then channel 3. With in_valid = 4'b1000 and ptr = 3, channel 3 is granted again.
5. **Fixed priority:** RR = 0, in_valid = 4'b0110 held → channel 1 is always granted and channel 2 is starved while channel 1 stays valid.
6. **Idle drain:** out_valid = 1, out_ready = 1, in_valid = 0 → out_valid = 0 on the next cycle. A later single-cycle in_valid[2] is accepted with zero wait.
